// File: rtl/fft_pkg.sv
// Shared constants, sequencer state encoding and the twiddle address rule for the
// FFT twiddle sequencer slice.
package fft_pkg;

  localparam int LOG2N   = 6;
  localparam int ADDR_W  = LOG2N - 1;
  localparam int DATA_W  = 16;
  localparam int STAGE_W = $clog2(LOG2N);
  localparam int NBFLY   = 1 << ADDR_W;
  localparam int FIFO_W  = 2 * DATA_W + STAGE_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  re;
    logic [DATA_W-1:0]  im;
    logic [STAGE_W-1:0] stage;
    logic [ADDR_W-1:0]  bfly;
  } tw_word_t;

  // Stage s uses 2^s distinct twiddles spread evenly over the N/2-entry table.
  function automatic logic [ADDR_W-1:0] tw_addr(input logic [STAGE_W-1:0] stage,
                                                input logic [ADDR_W-1:0]  bfly);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'((1 << stage) - 1);
    return (bfly & mask) << (ADDR_W - int'(stage));
  endfunction

endpackage

// File: rtl/fft_tw_skid_fifo.sv
// Two-entry FIFO that absorbs the ROM read latency between the sequencer and the
// butterfly stream; push and pop may coincide at any occupancy.
module fft_tw_skid_fifo
  import fft_pkg::*;
#(
  parameter int W = FIFO_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset because the empty FIFO's head drives the
      // twiddle outputs, which must read zero out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// FFT twiddle ROM read sequencer: walks every radix-2 DIT stage, reads one twiddle per
// butterfly and streams it with stage/butterfly tags. Define TWIDDLE_CONJ_EN to negate
// the imaginary part (saturating) on runs started with inverse=1.
module fft_twiddle_sequencer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              inverse,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_re,
  input  logic [DATA_W-1:0] rom_im,
  output logic              tw_valid,
  input  logic              tw_ready,
  output logic [DATA_W-1:0] tw_re,
  output logic [DATA_W-1:0] tw_im,
  output logic [2:0]        tw_stage,
  output logic [ADDR_W-1:0] tw_bfly,
  output logic              busy,
  output logic              done
);

  seq_state_e         state_q, state_d;
  logic [STAGE_W-1:0] stage_q;
  logic [ADDR_W-1:0]  bfly_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  issue_addr;
  logic               in_flight_q;
  logic [STAGE_W-1:0] if_stage_q;
  logic [ADDR_W-1:0]  if_bfly_q;
  logic [1:0]         fifo_count;
  logic [2:0]         occ_after;
  logic [DATA_W-1:0]  im_adj;
  tw_word_t           push_word, head_word;
  logic               start_ok, flush, pop, credit_ok, issue, last_issue;

  assign start_ok   = (state_q == IDLE) && start && !abort;
  assign flush      = (state_q != IDLE) && abort;
  assign pop        = tw_valid && tw_ready;
  // FIFO occupancy once this cycle's pop and pending ROM word settle; a read issued
  // now arrives on top of that, so at most one slot may already be spoken for.
  assign occ_after  = 3'(fifo_count) + 3'(in_flight_q) - 3'(pop);
  assign credit_ok  = (occ_after <= 3'd1);
  assign issue      = (state_q == RUN) && !abort && credit_ok;
  assign last_issue = issue && (stage_q == STAGE_W'(LOG2N - 1)) &&
                      (bfly_q == ADDR_W'(NBFLY - 1));

  always_comb begin
    // NOTE: the default comes first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (!in_flight_q && (fifo_count == 2'(pop))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign issue_addr = tw_addr(stage_q, bfly_q);
  assign rom_addr   = issue ? issue_addr : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      bfly_q      <= '0;
      addr_q      <= '0;
      in_flight_q <= 1'b0;
      if_stage_q  <= '0;
      if_bfly_q   <= '0;
    end else begin
      if (start_ok) begin
        stage_q <= '0;
        bfly_q  <= '0;
      end else if (issue) begin
        bfly_q <= bfly_q + 1'b1;
        if (bfly_q == ADDR_W'(NBFLY - 1)) begin
          stage_q <= last_issue ? '0 : stage_q + 1'b1;
        end
        addr_q     <= issue_addr;
        if_stage_q <= stage_q;
        if_bfly_q  <= bfly_q;
      end
      // issue is already low during an abort, so this also clears the flag on flush.
      in_flight_q <= issue;
    end
  end

`ifdef TWIDDLE_CONJ_EN
  logic inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        inv_q <= 1'b0;
    else if (start_ok) inv_q <= inverse;
  end

  // Negating the most negative value would overflow, so it saturates to the maximum.
  always_comb begin
    im_adj = rom_im;
    if (inv_q) begin
      im_adj = (rom_im == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}}
                                                       : -rom_im;
    end
  end
`else
  logic unused_inverse;
  assign unused_inverse = inverse;
  assign im_adj         = rom_im;
`endif

  assign push_word = {rom_re, im_adj, if_stage_q, if_bfly_q};

  fft_tw_skid_fifo #(
    .W(FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (in_flight_q),
    .pop   (pop),
    .din   (push_word),
    .dout  (head_word),
    .count (fifo_count)
  );

  assign tw_valid = (fifo_count != 2'd0);
  assign tw_re    = head_word.re;
  assign tw_im    = head_word.im;
  assign tw_stage = head_word.stage;
  assign tw_bfly  = head_word.bfly;
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE) && !abort;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Self-checking bench for fft_twiddle_sequencer: behavioural ROM, expected-word queue
// built from the stage/butterfly address rule, random back-pressure, abort and reset.
module tb_fft_twiddle_sequencer;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [2:0]  stage;
    logic [4:0]  bfly;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        inverse = 1'b0;
  logic        tw_ready = 1'b0;
  logic [4:0]  rom_addr;
  logic [15:0] rom_re = '0;
  logic [15:0] rom_im = '0;
  logic        tw_valid;
  logic [15:0] tw_re;
  logic [15:0] tw_im;
  logic [2:0]  tw_stage;
  logic [4:0]  tw_bfly;
  logic        busy;
  logic        done;
  logic        im_force = 1'b0;

  int    n_checks = 0;
  int    n_errors = 0;
  int    first_valid_iter;
  int    first_acc_iter;
  int    last_acc_iter;
  word_t exp_q[$];
  word_t rec[192];

`ifdef TWIDDLE_CONJ_EN
  localparam logic [15:0] EXP_IM_F003 = 16'h0FFD;
  localparam logic [15:0] EXP_IM_8000 = 16'h7FFF;
`else
  localparam logic [15:0] EXP_IM_F003 = 16'hF003;
  localparam logic [15:0] EXP_IM_8000 = 16'h8000;
`endif

  always #5 clk = ~clk;

  fft_twiddle_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .inverse  (inverse),
    .rom_addr (rom_addr),
    .rom_re   (rom_re),
    .rom_im   (rom_im),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .tw_stage (tw_stage),
    .tw_bfly  (tw_bfly),
    .busy     (busy),
    .done     (done)
  );

  // Twiddle ROM pair with one cycle of read latency.
  always @(posedge clk) begin
    rom_re <= 16'h1000 + 16'(rom_addr);
    rom_im <= im_force ? 16'h8000 : 16'hF000 + 16'(rom_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_im(input logic [15:0] raw, input logic inv);
`ifdef TWIDDLE_CONJ_EN
    if (inv) return (raw == 16'h8000) ? 16'h7FFF : 16'h0000 - raw;
    return raw;
`else
    // inverse has no effect in this build
    if (inv) return raw;
    return raw;
`endif
  endfunction

  function automatic void build_expected(input logic inv, input logic force_im);
    exp_q.delete();
    for (int s = 0; s < 6; s++) begin
      for (int b = 0; b < 32; b++) begin
        int    a;
        word_t w;
        a       = ((b % (1 << s)) * (1 << (5 - s))) % 32;
        w.re    = 16'h1000 + 16'(a);
        w.im    = exp_im(force_im ? 16'h8000 : 16'hF000 + 16'(a), inv);
        w.stage = 3'(s);
        w.bfly  = 5'(b);
        exp_q.push_back(w);
      end
    end
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rom_addr"}, 64'(rom_addr), 64'd0);
    check({pfx, "_tw_valid"}, 64'(tw_valid), 64'd0);
    check({pfx, "_tw_re"},    64'(tw_re),    64'd0);
    check({pfx, "_tw_im"},    64'(tw_im),    64'd0);
    check({pfx, "_tw_stage"}, 64'(tw_stage), 64'd0);
    check({pfx, "_tw_bfly"},  64'(tw_bfly),  64'd0);
    check({pfx, "_busy"},     64'(busy),     64'd0);
    check({pfx, "_done"},     64'(done),     64'd0);
  endtask

  // Start is seen at the next edge; the bench then sits in the first RUN cycle.
  task automatic start_run(input logic inv);
    @(negedge clk);
    start   = 1'b1;
    inverse = inv;
    @(negedge clk);
    start   = 1'b0;
    inverse = ~inv;
    #1;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Iteration i samples the (i+1)-th cycle after the first RUN cycle.
  task automatic consume(input int ready_pct, input int n_words, input bit poke_start);
    int          got;
    int          iter;
    logic        stalled;
    logic [40:0] held;
    logic [40:0] now_v;
    word_t       e;
    got = 0;
    iter = 0;
    stalled = 1'b0;
    held = '0;
    first_valid_iter = -1;
    first_acc_iter = -1;
    last_acc_iter = -1;
    while (got < n_words && iter < 4000) begin
      @(negedge clk);
      tw_ready = ($urandom_range(0, 99) < ready_pct);
      start    = poke_start && (iter == 20);
      #1;
      now_v = {tw_valid, tw_re, tw_im, tw_stage, tw_bfly};
      if (stalled) check("stall_hold", 64'(now_v), 64'(held));
      check("done_early", 64'(done), 64'd0);
      if (tw_valid && first_valid_iter < 0) first_valid_iter = iter;
      if (tw_valid && tw_ready) begin
        check("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("word%0d", got), 64'(now_v[39:0]), 64'(e));
        end
        if (got < 192) rec[got] = now_v[39:0];
        if (first_acc_iter < 0) first_acc_iter = iter;
        last_acc_iter = iter;
        got++;
      end
      stalled = tw_valid && !tw_ready;
      held    = now_v;
      iter++;
    end
    start = 1'b0;
    check("words_received", 64'(got), 64'(n_words));
  endtask

  task automatic finish_run();
    @(negedge clk);
    tw_ready = 1'b0;
    #1;
    check("done_pulse", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    check("no_extra_word", 64'(tw_valid), 64'd0);
    @(negedge clk);
    #1;
    check("done_single", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int bad;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("after_release");

    // Abort wins over a simultaneous start in IDLE.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("abort_beats_start", 64'(busy), 64'd0);

    // Full-rate run. First issue is the first RUN cycle, data is valid two cycles
    // later, i.e. consume iteration 1; then one word per cycle for 192 words.
    build_expected(1'b0, 1'b0);
    start_run(1'b0);
    consume(100, 192, 1'b0);
    check("first_valid_latency", 64'(first_valid_iter), 64'd1);
    check("back_to_back", 64'(last_acc_iter - first_acc_iter), 64'd191);
    finish_run();

    // Address spot checks from the recorded words (re = 0x1000 + address).
    bad = 0;
    for (int b = 0; b < 32; b++) if (rec[b].re != 16'h1000) bad++;
    check("s0_all_addr0", 64'(bad), 64'd0);
    check("s1_b1_addr16", 64'({rec[33].stage, rec[33].bfly, rec[33].re}),
          64'({3'd1, 5'd1, 16'h1010}));
    check("s2_b3_addr24", 64'({rec[67].stage, rec[67].bfly, rec[67].re}),
          64'({3'd2, 5'd3, 16'h1018}));
    check("s5_b31_addr31", 64'({rec[191].stage, rec[191].bfly, rec[191].re}),
          64'({3'd5, 5'd31, 16'h101F}));

    // Random back-pressure at 30% ready, with a stray start mid-run.
    build_expected(1'b0, 1'b0);
    start_run(1'b0);
    consume(30, 192, 1'b1);
    finish_run();

    // Abort after word 50, then a clean restart from s=0, b=0.
    build_expected(1'b0, 1'b0);
    start_run(1'b0);
    consume(100, 50, 1'b0);
    @(negedge clk);
    tw_ready = 1'b0;
    abort    = 1'b1;
    #1;
    check("done_during_abort", 64'(done), 64'd0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(tw_valid), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    #1;
    check("abort_no_late_push", 64'(tw_valid), 64'd0);
    build_expected(1'b0, 1'b0);
    start_run(1'b0);
    consume(100, 192, 1'b0);
    finish_run();

    // Async reset while draining the last words.
    build_expected(1'b0, 1'b0);
    start_run(1'b0);
    consume(100, 190, 1'b0);
    @(negedge clk);
    tw_ready = 1'b1;
    #1;
    check("busy_in_drain", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    build_expected(1'b0, 1'b0);
    start_run(1'b0);
    consume(50, 192, 1'b0);
    finish_run();

    // Inverse runs: conjugation when enabled, pass-through otherwise.
    build_expected(1'b1, 1'b0);
    start_run(1'b1);
    consume(100, 192, 1'b0);
    finish_run();
    check("conj_im_f003", 64'(rec[163].im), 64'(EXP_IM_F003));
    check("conj_re_kept", 64'(rec[163].re), 64'h1003);

    im_force = 1'b1;
    build_expected(1'b1, 1'b1);
    start_run(1'b1);
    consume(100, 192, 1'b0);
    finish_run();
    im_force = 1'b0;
    check("conj_im_8000", 64'(rec[0].im), 64'(EXP_IM_8000));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
